// File: rtl/icache_pkg.sv
// Shared constants for the instruction cache: default geometry, FSM state
// encodings and a saturating counter helper.
package icache_pkg;

  localparam int ICACHE_WORD_SIZE  = 16;
  localparam int ICACHE_LINE_WORDS = 4;
  localparam int ICACHE_NUM_LINES  = 4;
  localparam int ICACHE_CNT_W      = 16;

  typedef enum logic {
    ICACHE_STATE_IDLE = 1'b0,
    ICACHE_STATE_FILL = 1'b1
  } icache_state_e;

  function automatic logic [ICACHE_CNT_W-1:0] sat_inc(input logic [ICACHE_CNT_W-1:0] v);
    return (v == {ICACHE_CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/icache_cache_line_array.sv
// Valid/tag/data storage for the direct-mapped cache: one combinational read
// port, one write port and a synchronous clear of every valid bit.
module cache_line_array
  import icache_pkg::*;
#(
  parameter int WORD_SIZE  = ICACHE_WORD_SIZE,
  parameter int LINE_WORDS = ICACHE_LINE_WORDS,
  parameter int NUM_LINES  = ICACHE_NUM_LINES,
  parameter int IDX_W      = 2,
  parameter int TAG_W      = 12
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [IDX_W-1:0]                rd_index,
  output logic                            rd_valid,
  output logic [TAG_W-1:0]                rd_tag,
  output logic [LINE_WORDS*WORD_SIZE-1:0] rd_line,
  input  logic                            wr_en,
  input  logic [IDX_W-1:0]                wr_index,
  input  logic [TAG_W-1:0]                wr_tag,
  input  logic [LINE_WORDS*WORD_SIZE-1:0] wr_line,
  input  logic                            wr_valid,
  input  logic                            clear_all
);

  logic [NUM_LINES-1:0]            valid_q;
  logic [TAG_W-1:0]                tag_q  [NUM_LINES];
  logic [LINE_WORDS*WORD_SIZE-1:0] data_q [NUM_LINES];

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_line  = data_q[rd_index];

  // A write in the same cycle as a clear lands last; callers pass wr_valid=0 then.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
    end else begin
      if (clear_all) valid_q <= '0;
      if (wr_en) valid_q[wr_index] <= wr_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_index]  <= wr_tag;
      data_q[wr_index] <= wr_line;
    end
  end

endmodule

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache: zero-latency hits, whole-line
// fills over a mem_read/mem_valid handshake, saturating hit/miss counters.
module icache
  import icache_pkg::*;
#(
  parameter int WORD_SIZE  = ICACHE_WORD_SIZE,
  parameter int LINE_WORDS = ICACHE_LINE_WORDS,
  parameter int NUM_LINES  = ICACHE_NUM_LINES
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            i_mem_read,
  input  logic [WORD_SIZE-1:0]            i_address,
  input  logic                            invalidate,
  output logic                            i_ready,
  output logic [WORD_SIZE-1:0]            i_data,
  output logic                            mem_read,
  output logic [WORD_SIZE-1:0]            mem_address,
  input  logic [LINE_WORDS*WORD_SIZE-1:0] mem_data,
  input  logic                            mem_valid,
  output logic [ICACHE_CNT_W-1:0]         hit_count,
  output logic [ICACHE_CNT_W-1:0]         miss_count,
  output logic                            dbg_state
);

  // Handshake: mem_read rises the cycle after a miss and stays high until the
  // single mem_valid pulse; that pulse completes the fill and mem_read drops
  // the next cycle. mem_valid seen while not filling has no effect.

  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = WORD_SIZE - OFF_W - IDX_W;

  icache_state_e            state_q;
  logic                     mem_read_q;
  logic [WORD_SIZE-1:0]     mem_address_q;
  logic [IDX_W-1:0]         fill_idx_q;
  logic [TAG_W-1:0]         fill_tag_q;
  logic                     drop_q;
  logic [ICACHE_CNT_W-1:0]  hit_cnt_q, hit_cnt_d;
  logic [ICACHE_CNT_W-1:0]  miss_cnt_q, miss_cnt_d;

  logic [OFF_W-1:0]         addr_off;
  logic [IDX_W-1:0]         addr_idx;
  logic [TAG_W-1:0]         addr_tag;
  logic                     rd_valid;
  logic [TAG_W-1:0]         rd_tag;
  logic [LINE_WORDS*WORD_SIZE-1:0] rd_line;
  logic                     lookup, hit, miss;
  logic                     wr_en, wr_valid;

  assign addr_off = i_address[OFF_W-1:0];
  assign addr_idx = i_address[OFF_W +: IDX_W];
  assign addr_tag = i_address[WORD_SIZE-1 -: TAG_W];

  cache_line_array #(
    .WORD_SIZE  (WORD_SIZE),
    .LINE_WORDS (LINE_WORDS),
    .NUM_LINES  (NUM_LINES),
    .IDX_W      (IDX_W),
    .TAG_W      (TAG_W)
  ) u_lines (
    .clk       (clk),
    .reset_n   (reset_n),
    .rd_index  (addr_idx),
    .rd_valid  (rd_valid),
    .rd_tag    (rd_tag),
    .rd_line   (rd_line),
    .wr_en     (wr_en),
    .wr_index  (fill_idx_q),
    .wr_tag    (fill_tag_q),
    .wr_line   (mem_data),
    .wr_valid  (wr_valid),
    .clear_all (invalidate)
  );

  assign lookup = (state_q == ICACHE_STATE_IDLE) && i_mem_read && !invalidate;
  assign hit    = lookup && rd_valid && (rd_tag == addr_tag);
  assign miss   = lookup && !hit;

  // A fill overlapped by an invalidate still writes its data but stays invalid.
  assign wr_en    = (state_q == ICACHE_STATE_FILL) && mem_valid;
  assign wr_valid = !(drop_q || invalidate);

  assign hit_cnt_d  = hit  ? sat_inc(hit_cnt_q)  : hit_cnt_q;
  assign miss_cnt_d = miss ? sat_inc(miss_cnt_q) : miss_cnt_q;

  assign i_ready     = hit;
  assign i_data      = rd_line[addr_off*WORD_SIZE +: WORD_SIZE];
  assign mem_read    = mem_read_q;
  assign mem_address = mem_address_q;
  assign hit_count   = hit_cnt_q;
  assign miss_count  = miss_cnt_q;
  assign dbg_state   = state_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ICACHE_STATE_IDLE;
      mem_read_q    <= 1'b0;
      mem_address_q <= '0;
      fill_idx_q    <= '0;
      fill_tag_q    <= '0;
      drop_q        <= 1'b0;
      hit_cnt_q     <= '0;
      miss_cnt_q    <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      case (state_q)
        ICACHE_STATE_IDLE: begin
          if (miss) begin
            state_q       <= ICACHE_STATE_FILL;
            mem_read_q    <= 1'b1;
            mem_address_q <= {i_address[WORD_SIZE-1:OFF_W], {OFF_W{1'b0}}};
            fill_idx_q    <= addr_idx;
            fill_tag_q    <= addr_tag;
            drop_q        <= 1'b0;
          end
        end
        ICACHE_STATE_FILL: begin
          if (invalidate) drop_q <= 1'b1;
          if (mem_valid) begin
            state_q    <= ICACHE_STATE_IDLE;
            mem_read_q <= 1'b0;
            drop_q     <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: line-level reference model compared every
// cycle, a latency-configurable memory responder, and directed scenarios.
module tb_icache;

  logic        clk;
  logic        reset_n;
  logic        i_mem_read;
  logic [15:0] i_address;
  logic        invalidate;
  logic        i_ready;
  logic [15:0] i_data;
  logic        mem_read;
  logic [15:0] mem_address;
  logic [63:0] mem_data;
  logic        mem_valid;
  logic [15:0] hit_count;
  logic [15:0] miss_count;
  logic        dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  int lat_l    = 4;
  logic resp_en;
  logic stray_req;
  logic [15:0] exp_q[$];

  icache dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_mem_read  (i_mem_read),
    .i_address   (i_address),
    .invalidate  (invalidate),
    .i_ready     (i_ready),
    .i_data      (i_data),
    .mem_read    (mem_read),
    .mem_address (mem_address),
    .mem_data    (mem_data),
    .mem_valid   (mem_valid),
    .hit_count   (hit_count),
    .miss_count  (miss_count),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  // Backing memory contents: word at address a is {a[7:0], ~a[7:0]}.
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return {a[7:0], ~a[7:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h required %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- memory responder ----------------
  initial begin
    int cnt;
    cnt = 0;
    mem_valid = 1'b0;
    mem_data  = '0;
    forever begin
      @(posedge clk);
      #1;
      if (stray_req && reset_n) begin
        mem_valid = 1'b1;
        mem_data  = {$urandom, $urandom};
        stray_req = 1'b0;
      end else if (!reset_n || !resp_en) begin
        cnt = 0;
        mem_valid = 1'b0;
      end else if (mem_valid) begin
        mem_valid = 1'b0;
        cnt = 0;
      end else if (mem_read) begin
        cnt++;
        if (cnt == lat_l) begin
          mem_valid = 1'b1;
          for (int k = 0; k < 4; k++) mem_data[k*16 +: 16] = mem_word(mem_address + 16'(k));
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // ---------------- reference model ----------------
  // Cache contents held as line base addresses; data always comes from mem_word.
  logic        m_valid [4];
  logic [15:0] m_line  [4];
  logic        m_fill;
  logic        m_drop;
  logic [15:0] m_mem_addr;
  logic [15:0] m_hits;
  logic [15:0] m_misses;

  function automatic logic present(input logic [15:0] a);
    int idx;
    idx = int'((a >> 2) & 16'h3);
    return m_valid[idx] && (m_line[idx] == (a & 16'hFFFC));
  endfunction

  function automatic logic [15:0] sat16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) m_valid[i] <= 1'b0;
      for (int i = 0; i < 4; i++) m_line[i]  <= '0;
      m_fill     <= 1'b0;
      m_drop     <= 1'b0;
      m_mem_addr <= '0;
      m_hits     <= '0;
      m_misses   <= '0;
    end else if (!m_fill) begin
      if (i_mem_read && !invalidate) begin
        if (present(i_address)) begin
          m_hits <= sat16(m_hits);
        end else begin
          m_fill     <= 1'b1;
          m_drop     <= 1'b0;
          m_mem_addr <= i_address & 16'hFFFC;
          m_misses   <= sat16(m_misses);
        end
      end
      if (invalidate) for (int i = 0; i < 4; i++) m_valid[i] <= 1'b0;
    end else begin
      if (invalidate) begin
        m_drop <= 1'b1;
        for (int i = 0; i < 4; i++) m_valid[i] <= 1'b0;
      end
      if (mem_valid) begin
        m_line[int'((m_mem_addr >> 2) & 16'h3)]  <= m_mem_addr;
        m_valid[int'((m_mem_addr >> 2) & 16'h3)] <= !(m_drop || invalidate);
        m_fill <= 1'b0;
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    logic exp_ready;
    exp_ready = reset_n && !m_fill && i_mem_read && !invalidate && present(i_address);
    check("cmp_i_ready", i_ready, exp_ready);
    if (exp_ready) check("cmp_i_data", i_data, mem_word(i_address));
    check("cmp_mem_read", mem_read, m_fill);
    check("cmp_mem_address", mem_address, m_mem_addr);
    check("cmp_hit_count", hit_count, m_hits);
    check("cmp_miss_count", miss_count, m_misses);
    check("cmp_state", dbg_state, m_fill);
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(output int cyc);
    cyc = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (i_ready) return;
      cyc++;
    end
    check("ready_timeout", 32'd0, 32'd1);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int cyc;
    reset_n = 1'b0; i_mem_read = 1'b0; i_address = '0; invalidate = 1'b0;
    resp_en = 1'b1; stray_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check("rst_i_ready", i_ready, 0);
    check("rst_mem_read", mem_read, 0);
    check("rst_mem_address", mem_address, 16'h0000);
    check("rst_hit_count", hit_count, 0);
    check("rst_miss_count", miss_count, 0);

    // First miss on 0x0012 with L=4
    step(); i_mem_read = 1'b1; i_address = 16'h0012;
    @(negedge clk); check("t1_mem_read_lo", mem_read, 0);
    @(negedge clk); check("t1_mem_read_hi", mem_read, 1);
    check("t1_mem_address", mem_address, 16'h0010);
    wait_ready(cyc);
    check("t1_latency", cyc, 3);
    check("t1_data", i_data, 16'h12ED);
    check("t1_miss_count", miss_count, 1);

    // Consecutive hits in the same line
    exp_q.push_back(16'h10EF); exp_q.push_back(16'h11EE); exp_q.push_back(16'h13EC);
    foreach (exp_q[i]) begin end
    step(); i_address = 16'h0010; @(negedge clk);
    check("t2_ready_10", i_ready, 1); check("t2_data_10", i_data, exp_q.pop_front());
    step(); i_address = 16'h0011; @(negedge clk);
    check("t2_ready_11", i_ready, 1); check("t2_data_11", i_data, exp_q.pop_front());
    step(); i_address = 16'h0013; @(negedge clk);
    check("t2_ready_13", i_ready, 1); check("t2_data_13", i_data, exp_q.pop_front());
    step(); i_mem_read = 1'b0; @(negedge clk);
    check("t2_hit_count", hit_count, 4);
    check("t2_no_fill", mem_read, 0);

    // Conflict: 0x0050 evicts 0x0010
    step(); i_mem_read = 1'b1; i_address = 16'h0050;
    wait_ready(cyc);
    check("t3_data_50", i_data, 16'h50AF);
    check("t3_miss_count", miss_count, 2);
    step(); i_address = 16'h0010; @(negedge clk);
    check("t3_evicted", i_ready, 0);
    wait_ready(cyc);
    check("t3_data_10", i_data, 16'h10EF);
    check("t3_miss_count2", miss_count, 3);
    step(); i_mem_read = 1'b0;

    // Request changes mid-fill; original line still installed
    step(); invalidate = 1'b1;
    step(); invalidate = 1'b0;
    step(); i_mem_read = 1'b1; i_address = 16'h0010;
    step(); i_mem_read = 1'b0; i_address = 16'h0020;
    step(); i_mem_read = 1'b1; i_address = 16'h0024;
    wait_ready(cyc);
    check("t4_data_24", i_data, 16'h24DB);
    check("t4_miss_count", miss_count, 5);
    step(); i_address = 16'h0010; @(negedge clk);
    check("t4_orig_installed", i_ready, 1);
    check("t4_data_10", i_data, 16'h10EF);

    // Invalidate with valid lines, then during a fill
    step(); invalidate = 1'b1; @(negedge clk);
    check("t5_inv_blocks_ready", i_ready, 0);
    step(); invalidate = 1'b0; i_mem_read = 1'b0; @(negedge clk);
    check("t5_inv_no_fill", mem_read, 0);
    step(); i_mem_read = 1'b1; i_address = 16'h0038;
    step(); invalidate = 1'b1; i_mem_read = 1'b0;
    step(); invalidate = 1'b0;
    repeat (6) @(negedge clk);
    step(); i_mem_read = 1'b1; i_address = 16'h0038; @(negedge clk);
    check("t5_dropped_line", i_ready, 0);
    wait_ready(cyc);
    check("t5_data_38", i_data, 16'h38C7);
    check("t5_miss_count", miss_count, 7);
    step(); i_address = 16'h0024; @(negedge clk);
    check("t5_cleared_24", i_ready, 0);
    wait_ready(cyc);
    step(); i_address = 16'h0010; @(negedge clk);
    check("t5_cleared_10", i_ready, 0);
    wait_ready(cyc);
    check("t5_miss_count2", miss_count, 9);

    // Reset mid-fill, stray mem_valid, then saturate hit_count
    step(); i_address = 16'h0044;
    step();
    step(); resp_en = 1'b0; reset_n = 1'b0;
    @(negedge clk);
    check("t6_mem_read", mem_read, 0);
    check("t6_hit_count", hit_count, 0);
    check("t6_miss_count", miss_count, 0);
    step(); reset_n = 1'b1; i_mem_read = 1'b0; stray_req = 1'b1;
    repeat (4) step();
    resp_en = 1'b1; i_mem_read = 1'b1; i_address = 16'h0044;
    @(negedge clk);
    check("t6_nothing_installed", i_ready, 0);
    wait_ready(cyc);
    check("t6_data_44", i_data, 16'h44BB);
    check("t6_miss_count2", miss_count, 1);
    repeat (65540) @(negedge clk);
    check("t6_hit_saturated", hit_count, 16'hFFFF);
    step(); i_mem_read = 1'b0;
    @(negedge clk);
    check("t6_hit_held", hit_count, 16'hFFFF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
